ft64_ifetch_aligner: RTL and testbench

Instruction-alignment buffer between the instruction cache fetch port and the decode/expand stage. Accepts 64-bit little-endian fetch words, packs them into an 8-halfword queue, and delivers one variable-length instruction (16, 32 or 48 bits) per cycle with its PC. Compressed (16-bit) instructions are handed to the compressed-instruction expander stage downstream, which is optionally folded in here.

---
 rtl/ft64_ifetch_aligner.sv | 110 +++++++++++
 tb/tb_ft64_ifetch_aligner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ft64_ifetch_aligner.sv
// Fetch-word to instruction aligner: 8-halfword queue, one 16/32/48-bit instr per cycle; FT64_ALIGN_EXPAND_EN folds in the expander.
// Latency: a word accepted at edge N is visible at the head after edge N; outputs are decoded from registered state only.
// Backpressure: in_ready drops once more than 4 halfwords are queued; out_valid holds head stable until out_ready.
module ft64_ifetch_aligner #(
   parameter int              AMSB  = 31,
   parameter logic [AMSB:0]   RSTPC = 32'hFFFC0100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [AMSB:0]     flush_pc,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [47:0]       out_instr,
   output logic [1:0]        out_len,
   output logic              out_cmp,
   output logic [AMSB:0]     out_pc
);

   logic [15:0]   slot [8];
   logic [2:0]    head;
   logic [3:0]    count;
   logic [1:0]    skip;
   logic [AMSB:0] pc;

   logic [15:0]   h0, h1, h2;
   logic [1:0]    len;
   logic          push, pop;
   logic [2:0]    tail;
   logic [2:0]    push_n;
   logic          unused_flush_lsb;

   assign unused_flush_lsb = flush_pc[0];

   assign h0 = slot[head];
   assign h1 = slot[head + 3'd1];
   assign h2 = slot[head + 3'd2];

   always_comb begin
      len = 2'd2;
      case (h0[7:6])
         2'b11:   len = 2'd1;
         2'b01:   len = 2'd3;
         default: len = 2'd2;
      endcase
   end

`ifdef FT64_ALIGN_EXPAND_EN
   // Expanded form: sign-extended immediate from the upper byte, opcode kept, [7:6] marked 2'b10.
   function automatic logic [47:0] expand(input logic [15:0] h);
      return {{26{h[15]}}, h[15:8], h[5:0], 2'b10, h[5:0]};
   endfunction
`endif

   always_comb begin
      out_instr = 48'd0;
      case (len)
`ifdef FT64_ALIGN_EXPAND_EN
         2'd1:    out_instr = expand(h0);
`else
         2'd1:    out_instr = {32'd0, h0};
`endif
         2'd3:    out_instr = {h2, h1, h0};
         default: out_instr = {16'd0, h1, h0};
      endcase
   end

   assign out_len   = len;
   assign out_cmp   = (h0[7:6] == 2'b11);
   assign out_pc    = pc;
   assign out_valid = (count != 4'd0) && (count >= {2'b00, len});
   assign in_ready  = (count <= 4'd4);

   assign push   = in_valid && in_ready;
   assign pop    = out_valid && out_ready;
   assign tail   = head + count[2:0];
   assign push_n = 3'd4 - {1'b0, skip};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++)
            slot[i] <= 16'd0;
         head  <= 3'd0;
         count <= 4'd0;
         skip  <= RSTPC[2:1];
         pc    <= {RSTPC[AMSB:1], 1'b0};
      end else if (flush) begin
         count <= 4'd0;
         skip  <= flush_pc[2:1];
         pc    <= {flush_pc[AMSB:1], 1'b0};
      end else begin
         if (push) begin
            // Leading halfwords below the restart PC are dropped from the first word after a flush.
            for (int k = 0; k < 4; k++)
               if (k >= int'(skip))
                  slot[tail + 3'(k) - {1'b0, skip}] <= in_data[16*k +: 16];
            skip <= 2'd0;
         end
         if (pop) begin
            head <= head + {1'b0, len};
            pc   <= pc + (AMSB+1)'({len, 1'b0});
         end
         count <= count - (pop ? {2'b00, len} : 4'd0) + (push ? {1'b0, push_n} : 4'd0);
      end
   end

endmodule

// File: tb/tb_ft64_ifetch_aligner.sv
// Randomized and directed bench for ft64_ifetch_aligner against a halfword-queue reference model.
module tb_ft64_ifetch_aligner;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_cmp;
   logic [31:0] flush_pc, out_pc;
   logic [63:0] in_data;
   logic [47:0] out_instr;
   logic [1:0]  out_len;

   int nchecks = 0;
   int nerrors = 0;

   logic [15:0] mq[$];
   logic [31:0] mpc;
   int          mskip;

   always #5 clk = ~clk;

   ft64_ifetch_aligner #(.AMSB(31), .RSTPC(32'hFFFC0100)) dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_len(out_len), .out_cmp(out_cmp), .out_pc(out_pc)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int mlen();
      if (mq.size() == 0) return 2;
      case (mq[0][7:6])
         2'b11:   return 1;
         2'b01:   return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [47:0] minstr(input int len);
      logic [47:0] r;
      r = 48'd0;
      for (int i = 0; i < len; i++) r[16*i +: 16] = mq[i];
`ifdef FT64_ALIGN_EXPAND_EN
      if (len == 1)
         r = {{26{mq[0][15]}}, mq[0][15:8], mq[0][5:0], 2'b10, mq[0][5:0]};
`endif
      return r;
   endfunction

   // Compare against the model at the current (negedge) point, then apply one cycle of stimulus.
   task automatic step(input logic fl, input logic [31:0] fpc, input logic iv,
                       input logic [63:0] d, input logic ordy);
      int  len;
      bit  vld, rdy;
      len = mlen();
      vld = (mq.size() >= 1) && (mq.size() >= len);
      rdy = (mq.size() <= 4);
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("out_valid", 64'(out_valid), 64'(vld));
      check("out_pc", 64'(out_pc), 64'(mpc));
      if (vld) begin
         check("out_len", 64'(out_len), 64'(len));
         check("out_cmp", 64'(out_cmp), 64'(len == 1));
         check("out_instr", 64'(out_instr), 64'(minstr(len)));
      end
      flush = fl; flush_pc = fpc; in_valid = iv; in_data = d; out_ready = ordy;
      if (fl) begin
         mq.delete();
         mpc   = {fpc[31:1], 1'b0};
         mskip = int'(fpc[2:1]);
      end else begin
         if (vld && ordy) begin
            for (int i = 0; i < len; i++) void'(mq.pop_front());
            mpc = mpc + 32'(2 * len);
         end
         if (iv && rdy) begin
            for (int k = mskip; k < 4; k++) mq.push_back(d[16*k +: 16]);
            mskip = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; flush_pc = 32'd0; in_valid = 1'b0;
      in_data = 64'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete(); mpc = 32'hFFFC0100; mskip = 0;

      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_out_len", 64'(out_len), 64'd2);
      check("rst_out_cmp", 64'(out_cmp), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'hFFFC0100);

      // first word: compressed head visible one cycle after acceptance
      step(0, 0, 1, 64'h0000_00C3_0000_00C1, 0);
      check("first_valid", 64'(out_valid), 64'd1);
      check("first_pc", 64'(out_pc), 64'hFFFC0100);
      check("first_len", 64'(out_len), 64'd1);
      check("first_cmp", 64'(out_cmp), 64'd1);
      step(0, 0, 0, 64'd0, 1);
      check("second_pc", 64'(out_pc), 64'hFFFC0102);
      step(0, 0, 0, 64'd0, 1);
      step(0, 0, 0, 64'd0, 1);

      // 48-bit instruction straddling two fetch words
      step(1, 32'h0000_1000, 0, 64'd0, 0);
      step(0, 0, 1, {16'h0040, 16'h00C0, 16'h00C0, 16'h00C0}, 0);
      repeat (3) step(0, 0, 0, 64'd0, 1);
      check("straddle_held", 64'(out_valid), 64'd0);
      step(0, 0, 1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0);
      check("straddle_valid", 64'(out_valid), 64'd1);
      check("straddle_instr", 64'(out_instr), 64'h0000_2222_1111_0040);
      check("straddle_len", 64'(out_len), 64'd3);
      step(0, 0, 0, 64'd0, 1);

      // flush into the middle of a fetch word
      step(1, 32'h0000_0106, 0, 64'd0, 0);
      step(0, 0, 1, {16'h00C7, 16'hAAAA, 16'hBBBB, 16'hCCCC}, 0);
      check("flush106_pc", 64'(out_pc), 64'h0000_0106);
      check("flush106_instr", 64'(out_instr[15:0]), 64'h00C7);
      step(0, 0, 0, 64'd0, 1);

      // backpressure: fill to 8 halfwords with decode stalled
      step(1, 32'h0000_2000, 0, 64'd0, 0);
      step(0, 0, 1, {16'h0010, 16'h0011, 16'h0012, 16'h0013}, 0);
      step(0, 0, 1, {16'h0020, 16'h0021, 16'h0022, 16'h0023}, 0);
      check("full_in_ready", 64'(in_ready), 64'd0);
      step(0, 0, 1, {16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF}, 0);
      step(0, 0, 1, {16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF}, 1);

      // flush wins over simultaneous push and pop
      step(1, 32'h0000_3000, 1, {16'h0030, 16'h0031, 16'h0032, 16'h0033}, 1);
      check("flushpp_valid", 64'(out_valid), 64'd0);
      check("flushpp_pc", 64'(out_pc), 64'h0000_3000);

      // sustained 32-bit stream
      repeat (24) step(0, 0, 1, {16'h1234, 16'h0010, 16'h5678, 16'h0020}, 1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 49) == 0, $urandom, $urandom_range(0, 3) != 0,
              {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
